// File: rtl/mem_arb_pkg.sv
// Types shared by the unified-memory arbiter and its response pipeline.
package mem_arb_pkg;

   typedef enum logic {
      SRC_INSTR = 1'b0,
      SRC_DATA  = 1'b1
   } src_t;

   typedef struct packed {
      logic valid;
      src_t src;
   } resp_tag_t;

   localparam int MAX_READ_LATENCY = 4;

endpackage : mem_arb_pkg

// File: rtl/resp_pipe.sv
// Fixed-depth delay line of read tags, aligning each issued read with the
// memory data that returns LATENCY cycles later.
module resp_pipe
   import mem_arb_pkg::*;
#(
   parameter int LATENCY = 1
) (
   input  logic      clk,
   input  logic      clear,
   input  resp_tag_t tagIn,
   output resp_tag_t tagOut
);

   resp_tag_t stages [LATENCY];

   // NOTE: this array is cleared on reset because a stale valid bit would
   // deliver a phantom response; storage without control meaning would not be.
   always_ff @(posedge clk) begin
      if (clear) begin
         for (int i = 0; i < LATENCY; i++) begin
            stages[i] <= '0;
         end
      end else begin
         stages[0] <= tagIn;
         for (int i = 1; i < LATENCY; i++) begin
            stages[i] <= stages[i-1];
         end
      end
   end

   assign tagOut = stages[LATENCY-1];

endmodule : resp_pipe

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between the instruction
// fetch port and the load/store port, with in-order read response routing.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int READ_LATENCY = 1,
   parameter int CNT_W        = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_gnt,
   output logic              i_rvalid,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_gnt,
   output logic              d_rvalid,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_en,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic [CNT_W-1:0]  conflict_cnt
);

   src_t           lastSrc;
   logic           grantI;
   logic           grantD;
   resp_tag_t      issueTag;
   resp_tag_t      returnTag;
   logic [CNT_W-1:0] conflictCnt;

   // NOTE: every combinational output gets a default first so no path through
   // the block leaves it unassigned, which would infer a latch.
   always_comb begin
      grantI = 1'b0;
      grantD = 1'b0;
      if (!reset) begin
         if (i_req && d_req) begin
            // On conflict the source that did not win last time goes first.
            if (lastSrc == SRC_DATA) grantI = 1'b1;
            else                     grantD = 1'b1;
         end else if (i_req) begin
            grantI = 1'b1;
         end else if (d_req) begin
            grantD = 1'b1;
         end
      end
   end

   always_comb begin
      issueTag       = '0;
      issueTag.valid = grantI || (grantD && !d_we);
      issueTag.src   = grantD ? SRC_DATA : SRC_INSTR;
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge values regardless of process evaluation order.
   always_ff @(posedge clk) begin
      if (reset) begin
         lastSrc <= SRC_INSTR;
      end else if (grantI) begin
         lastSrc <= SRC_INSTR;
      end else if (grantD) begin
         lastSrc <= SRC_DATA;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         conflictCnt <= '0;
      end else if (i_req && d_req && (conflictCnt != {CNT_W{1'b1}})) begin
         conflictCnt <= conflictCnt + CNT_W'(1);
      end
   end

   resp_pipe #(
      .LATENCY (READ_LATENCY)
   ) uRespPipe (
      .clk    (clk),
      .clear  (reset),
      .tagIn  (issueTag),
      .tagOut (returnTag)
   );

   assign i_gnt     = grantI;
   assign d_gnt     = grantD;
   assign mem_en    = grantI || grantD;
   assign mem_we    = grantD && d_we;
   assign mem_addr  = grantD ? d_addr : i_addr;
   assign mem_wdata = d_wdata;

   // Gating with reset keeps responses quiet during the cycle reset is raised.
   assign i_rvalid = !reset && returnTag.valid && (returnTag.src == SRC_INSTR);
   assign d_rvalid = !reset && returnTag.valid && (returnTag.src == SRC_DATA);
   assign i_rdata  = mem_rdata;
   assign d_rdata  = mem_rdata;

   assign conflict_cnt = conflictCnt;

endmodule : mem_arbiter

// File: tb/tb_mem_arbiter.sv
// Randomized scoreboard bench for mem_arbiter with a behavioural memory and
// an independent arbitration/memory reference model.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int RL     = 3;
   localparam int CNT_W  = 4;
   localparam int CNT_MAX = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              reset;
   logic              i_req;
   logic [ADDR_W-1:0] i_addr;
   logic              i_gnt;
   logic              i_rvalid;
   logic [DATA_W-1:0] i_rdata;
   logic              d_req;
   logic              d_we;
   logic [ADDR_W-1:0] d_addr;
   logic [DATA_W-1:0] d_wdata;
   logic              d_gnt;
   logic              d_rvalid;
   logic [DATA_W-1:0] d_rdata;
   logic              mem_en;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic [CNT_W-1:0]  conflict_cnt;

   mem_arbiter #(
      .ADDR_W       (ADDR_W),
      .DATA_W       (DATA_W),
      .READ_LATENCY (RL),
      .CNT_W        (CNT_W)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .i_req        (i_req),
      .i_addr       (i_addr),
      .i_gnt        (i_gnt),
      .i_rvalid     (i_rvalid),
      .i_rdata      (i_rdata),
      .d_req        (d_req),
      .d_we         (d_we),
      .d_addr       (d_addr),
      .d_wdata      (d_wdata),
      .d_gnt        (d_gnt),
      .d_rvalid     (d_rvalid),
      .d_rdata      (d_rdata),
      .mem_en       (mem_en),
      .mem_we       (mem_we),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_rdata    (mem_rdata),
      .conflict_cnt (conflict_cnt)
   );

   always #5 clk = ~clk;

   int nVec  = 0;
   int nFail = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nVec++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s @cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
      end
   endtask

   // Behavioural memory macro attached to the DUT's memory port.
   logic [DATA_W-1:0] phys   [256];
   logic [DATA_W-1:0] shadow [256];
   logic [DATA_W-1:0] rdPipe [RL];

   assign mem_rdata = rdPipe[RL-1];

   always @(posedge clk) begin
      logic [DATA_W-1:0] rd;
      rd = $urandom;
      if (mem_en) begin
         if (mem_we) phys[mem_addr[9:2]] = mem_wdata;
         else        rd = phys[mem_addr[9:2]];
      end
      rdPipe[0] <= rd;
      for (int i = 1; i < RL; i++) rdPipe[i] <= rdPipe[i-1];
   end

   // Reference model: expected grants, memory-port values and responses.
   typedef struct {
      src_t              src;
      logic [DATA_W-1:0] data;
      int                due;
   } exp_t;

   exp_t sb[$];
   src_t mLast     = SRC_INSTR;
   int   mCnt      = 0;
   bit   mCntValid = 1'b0;

   always @(negedge clk) begin
      bit eI, eD;
      if (reset) begin
         check("rst_gnt", {i_gnt, d_gnt, mem_en, mem_we}, 4'b0000);
         if (mCntValid) check("rst_cnt", conflict_cnt, mCnt);
         mCnt = 0;
         mCntValid = 1'b1;
         mLast = SRC_INSTR;
         sb.delete();
      end else begin
         eI = i_req && (!d_req || mLast == SRC_DATA);
         eD = d_req && !eI;
         check("gnt", {i_gnt, d_gnt}, {eI, eD});
         check("mem_en", mem_en, eI || eD);
         if (eI) begin
            check("mem_addr_i", mem_addr, i_addr);
            check("mem_we_i", mem_we, 1'b0);
            sb.push_back('{SRC_INSTR, shadow[i_addr[9:2]], cyc + RL});
            mLast = SRC_INSTR;
         end
         if (eD) begin
            check("mem_addr_d", mem_addr, d_addr);
            check("mem_we_d", mem_we, d_we);
            if (d_we) begin
               check("mem_wdata", mem_wdata, d_wdata);
               shadow[d_addr[9:2]] = d_wdata;
            end else begin
               sb.push_back('{SRC_DATA, shadow[d_addr[9:2]], cyc + RL});
            end
            mLast = SRC_DATA;
         end
         check("conflict_cnt", conflict_cnt, mCnt);
         if (i_req && d_req) mCnt = (mCnt == CNT_MAX) ? CNT_MAX : mCnt + 1;
      end
   end

   // Monitor: pops the scoreboard whenever a response appears or is due.
   always @(negedge clk) begin
      exp_t e;
      if (reset) begin
         check("rst_rvalid", {i_rvalid, d_rvalid}, 2'b00);
      end else if (i_rvalid || d_rvalid || (sb.size() > 0 && sb[0].due <= cyc)) begin
         check("rvalid_excl", i_rvalid && d_rvalid, 1'b0);
         if (sb.size() == 0) begin
            check("spurious_rvalid", {i_rvalid, d_rvalid}, 2'b00);
         end else begin
            e = sb.pop_front();
            check("rsp_cycle", cyc, e.due);
            check("rsp_src", {i_rvalid, d_rvalid}, (e.src == SRC_DATA) ? 2'b01 : 2'b10);
            check("rsp_data", (e.src == SRC_DATA) ? d_rdata : i_rdata, e.data);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      bit iG, dG;
      for (int i = 0; i < 256; i++) begin
         phys[i]   = 32'h9E37_79B1 * (i + 1);
         shadow[i] = 32'h9E37_79B1 * (i + 1);
      end
      phys[0]   = 32'h0000_0093;
      shadow[0] = 32'h0000_0093;
      phys[1]   = 32'h0010_0113;
      shadow[1] = 32'h0010_0113;

      // Reset with both requesting, then a long conflict run to saturation.
      reset = 1'b1;
      i_req = 1'b1; i_addr = 32'h40;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h100; d_wdata = '0;
      tick(); tick();
      reset = 1'b0;
      #3;
      check("first_conflict_data", {i_gnt, d_gnt}, 2'b01);
      check("first_conflict_addr", mem_addr, 32'h100);
      repeat (20) tick();
      check("cnt_saturated", conflict_cnt, CNT_MAX);

      // Back-to-back fetches.
      d_req = 1'b0; i_addr = 32'h0;
      tick();
      i_addr = 32'h4;
      tick();
      i_req = 1'b0;
      repeat (RL + 1) tick();

      // Store then load of the same word.
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'h1FE;
      tick();
      d_we = 1'b0;
      tick();
      d_req = 1'b0;
      repeat (RL + 1) tick();

      // Two reads in flight, then reset discards them.
      i_req = 1'b1; i_addr = 32'h20;
      tick();
      i_addr = 32'h24;
      tick();
      reset = 1'b1;
      tick();
      reset = 1'b0; i_req = 1'b0;
      repeat (RL + 2) tick();

      // Randomized traffic with held pending requests and rare resets.
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         iG = i_gnt;
         dG = d_gnt;
         @(posedge clk);
         #1;
         reset = ($urandom_range(99) == 0);
         if (!i_req || iG) begin
            i_req  = ($urandom_range(3) != 0);
            i_addr = ADDR_W'($urandom_range(255)) << 2;
         end else if ($urandom_range(15) == 0) begin
            i_req = 1'b0;
         end
         if (!d_req || dG) begin
            d_req   = ($urandom_range(3) != 0);
            d_we    = ($urandom_range(2) == 0);
            d_addr  = ADDR_W'($urandom_range(255)) << 2;
            d_wdata = $urandom;
         end else if ($urandom_range(15) == 0) begin
            d_req = 1'b0;
         end
      end

      reset = 1'b0; i_req = 1'b0; d_req = 1'b0;
      repeat (RL + 3) tick();
      check("scoreboard_drained", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
      $finish;
   end

endmodule : tb_mem_arbiter

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port unified instruction/data memory between the cpu instruction-fetch port and data (load/store) port. Per-cycle req/gnt handshake, round-robin on conflict. Tags every issued read and routes the response READ_LATENCY cycles later. Keeps a saturating conflict counter for performance debug. Sits between cpu and the memory macro.

Parameters:
ADDR_W, 32, address width in bits (byte address, passed through unchanged)
DATA_W, 32, data width in bits
READ_LATENCY, 1, cycles from mem_en (read) to valid mem_rdata; legal range 1..4
CNT_W, 16, width of conflict_cnt

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
i_req  input  1  instruction fetch request
i_addr  input  ADDR_W  fetch address; stable while i_req && !i_gnt
i_gnt  output  1  fetch accepted this cycle
i_rvalid  output  1  fetch data valid on i_rdata
i_rdata  output  DATA_W  fetch data
d_req  input  1  data request
d_we  input  1  1 = store, 0 = load
d_addr  input  ADDR_W  data address
d_wdata  input  DATA_W  store data
d_gnt  output  1  data request accepted this cycle
d_rvalid  output  1  load data valid on d_rdata
d_rdata  output  DATA_W  load data
mem_en  output  1  memory access strobe
mem_we  output  1  memory write enable
mem_addr  output  ADDR_W  memory address
mem_wdata  output  DATA_W  memory write data
mem_rdata  input  DATA_W  memory read data, READ_LATENCY after a read strobe
conflict_cnt  output  CNT_W  count of cycles with i_req && d_req, saturating

Behaviour:
- Clock is clk; reset is synchronous, active-high, sampled on the rising edge only.
- While reset is high, outputs are gnt=0, mem_en=0, mem_we=0, rvalids=0. At the first edge with reset high: last_src <= INSTR, response pipeline cleared, conflict_cnt <= 0. mem_addr and mem_wdata are don't-care when mem_en=0.
- Grant logic is combinational from req and last_src. At most one gnt per cycle.
  - Only one requester: that one is granted.
  - Both requesting: the one NOT equal to last_src is granted. After reset, data wins the first conflict.
- last_src updates to the granted source on every grant and holds when idle.
- On grant, mem_en=1 and mem_addr equals the granted address.
  - Data grant: mem_we=d_we, mem_wdata=d_wdata.
  - Instruction grant: mem_we=0.
- A requester whose req is high without gnt must hold its address and data. Dropping req before grant is legal; the arbiter keeps no record of it.
- Response pipeline: a shift register of READ_LATENCY stages, each holding {valid, src}.
  - Stage 0 loads {1, src} on a read grant, else {0, x}.
  - Writes never produce a response. A store is complete at d_gnt.
- i_rvalid is 1 when the last stage is valid with src=INSTR; d_rvalid is 1 when it is valid with src=DATA. Never both in one cycle.
- i_rdata and d_rdata both equal mem_rdata. Only the matching rvalid qualifies them.
- Throughput: one grant per cycle, reads fully pipelined. A new read may issue while earlier reads are in flight. Responses return in issue order.
- conflict_cnt increments by 1 on each edge where i_req && d_req && !reset, and saturates at all-ones.
- Reset mid-operation: all in-flight reads are discarded. No rvalid asserts on the cycle after reset is sampled. Requesters must reissue.
- Simultaneous grant and response in one cycle is normal and independent.

Decomposition:
- Shared package mem_arb_pkg holds:
  - typedef enum logic {SRC_INSTR, SRC_DATA} src_t
  - struct resp_tag_t {valid, src}
  - localparam MAX_READ_LATENCY = 4
- One sub-module, resp_pipe: a parameterised READ_LATENCY-deep shift register of resp_tag_t with synchronous clear.
- Grant logic and counter stay in mem_arbiter.

Test Plan:
- Reset held for 2 cycles with i_req=d_req=1 -> i_gnt=d_gnt=mem_en=0, conflict_cnt=0. After release, the first cycle grants data (d_gnt=1, mem_addr=d_addr).
- Fetch only: i_addr=0x0 then 0x4 on back-to-back cycles, READ_LATENCY=1, mem_rdata=0x00000093, 0x00100113 -> i_gnt=1 both cycles; i_rvalid=1 on cycles +1 and +2 with those values; d_rvalid=0.
- Conflict: i_req=d_req=1 held for 4 cycles, load d_addr=0x100 -> grants alternate D, I, D, I; conflict_cnt=4; each read response is tagged to its issuer.
- Store then load: d_we=1, d_addr=0x10, d_wdata=0x1FE, then load 0x10 -> first mem_we=1, mem_wdata=0x1FE, no d_rvalid. Second access gives d_rvalid after READ_LATENCY with mem_rdata passed through.
- READ_LATENCY=3: reads at cycles 0, 1, 2 -> rvalids at cycles 3, 4, 5 in order. Reset asserted at cycle 2 -> no rvalid at cycles 3–5.
- CNT_W=4: hold both reqs for 20 cycles -> conflict_cnt stops at 15.
